mdu_sequencer: RTL
==================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the P6 pipeline's Execute stage. It accepts one mult/multu/div/divu start pulse from the E-stage decode, holds the unit busy for the architectural latency, and commits the result to HI/LO only at the end of that latency. It also services mthi/mtlo and raises the D-stage stall request that keeps HI/LO-dependent instructions out of Execute while an operation is pending.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk` input 1: the block's only clock.
- `reset` input 1: asynchronous, active-high reset.
- `Start` input 1: E-stage mult/multu/div/divu accept pulse (`MDU_Start`).
- `Op` input 3: operation. 0 = mult, 1 = multu, 2 = div, 3 = divu; 4–7 reserved.
- `A` input 32: rs operand (forwarded value).
- `B` input 32: rt operand (forwarded value).
- `HI_Write` input 1: mthi in E; writes `A` to HI.
- `LO_Write` input 1: mtlo in E; writes `A` to LO.
- `isMDFT_D` input 1: D-stage instruction is mult/div/mf/mt/shl.
- `Busy` output 1: operation in flight.
- `Stall` output 1: `isMDFT_D & (Start | Busy)`; combinational.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- Reset values: FSM is IDLE; `HI`, `LO` and internal pending registers are 0; counter is 0; `Busy` is 0; `Stall` is 0 while `isMDFT_D` is 0.
- FSM states: IDLE and RUN.
  - IDLE → RUN on `Start` with Op 0–3.
  - RUN → IDLE when counter = 1 at a clock edge.
  - Start with Op ≥ 4 is ignored; the FSM stays IDLE and HI/LO are unchanged.
- On accept, the result is computed from `A`/`B` in that cycle and latched into pend_hi/pend_lo:
  - mult: signed 32×32, 64-bit product. HI gets bits [63:32], LO gets bits [31:0].
  - multu: same split, unsigned product.
  - div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - divu: unsigned. LO = quotient, HI = remainder.
  - Division by zero: the pending values equal the current HI/LO, so the commit leaves them unchanged. Full latency still applies.
- Counter is loaded with `MULT_CYCLES` or `DIV_CYCLES` on accept and decrements each RUN cycle.
- Commit: at the edge where counter = 1, HI ← pend_hi and LO ← pend_lo, and the FSM returns to IDLE.
- `Busy` is high exactly while in RUN.
- `HI_Write` / `LO_Write` in IDLE: the selected register takes `A` at the next edge. Both asserted together writes both.
- Simultaneous events:
  - `Start` while in RUN: ignored; no restart, pending values untouched.
  - `HI_Write`/`LO_Write` while in RUN: ignored. The hazard unit prevents both cases; the block must still be robust to them.
  - `Start` and `HI_Write` in the same IDLE cycle: `Start` wins, and the mt write is dropped.
- `reset` asserted mid-operation: abort immediately to the reset state; no commit occurs.

## Timing
- `Start` sampled at edge k (cycle k−1 → k). `Busy` = 1 from just after edge k until just after edge k+N, where N is the op latency. The HI/LO update is visible after edge k+N, the same edge at which `Busy` falls.
- mult: `Busy` is high for 5 cycles; the new HI/LO is first readable in the 6th cycle after the Start cycle. div: 10 and 11 respectively.
- Back-to-back: a new `Start` is accepted in the first cycle where `Busy` = 0, i.e. the cycle right after the commit edge. This gives zero idle cycles between operations.
- mthi/mtlo latency: 1 edge.
- `Stall` is asserted in the Start cycle itself, so an mfhi directly behind a mult never reaches E early. `Stall` has no registered delay.
- `HI`/`LO` are register outputs only; they do not change combinationally.

## Test plan
- Reset: `reset` = 1 with all inputs random → `HI` = `LO` = 0, `Busy` = 0. `Stall` follows `isMDFT_D & Start` only.
- mult: `A` = 0xFFFFFFFE (−2), `B` = 3, Op = 0, Start for 1 cycle.
  - `Busy` is high for exactly 5 cycles.
  - Afterwards HI = 0xFFFFFFFF and LO = 0xFFFFFFFA.
  - With `isMDFT_D` = 1 throughout, `Stall` is high for 6 consecutive cycles.
- multu: same operands, Op = 1 → HI = 0x00000002, LO = 0xFFFFFFFA after 5 busy cycles.
- div/divu:
  - `A` = 0xFFFFFFF9 (−7), `B` = 2, Op = 2 → 10 busy cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Then Op = 3 with `B` = 0 → `Busy` high for 10 cycles; HI/LO are unchanged afterwards.
- mt and collision:
  - mthi `A` = 0x12345678 in IDLE → HI = 0x12345678 after 1 edge.
  - Start a div, then pulse `HI_Write` and a second `Start` in busy cycle 3 → both ignored. Only the div result commits, at busy cycle 10.
- Reset mid-op: start mult, assert `reset` in busy cycle 2 → `Busy` = 0 and HI = LO = 0 immediately. No later commit occurs, and a new Start is accepted after reset is released.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Bundle between the E-stage control/operand path and the multiply/divide
// sequencer: start/op/operands and mt writes in, busy/stall and HI/LO out.
`timescale 1ns/1ps
interface mdu_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              Start;
  logic [2:0]        Op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              HI_Write;
  logic              LO_Write;
  logic              isMDFT_D;
  logic              Busy;
  logic              Stall;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output Start, Op, A, B, HI_Write, LO_Write, isMDFT_D,
    input  Busy, Stall, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, HI_Write, LO_Write, isMDFT_D,
    output Busy, Stall, HI, LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/multu/div/divu sequencer: the result is computed on accept,
// held pending for the architectural latency, then committed to HI/LO.
`timescale 1ns/1ps
module mdu_sequencer #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  hi_q;
  logic [DATA_W-1:0]  lo_q;
  logic [DATA_W-1:0]  pend_hi_q;
  logic [DATA_W-1:0]  pend_lo_q;
  logic [DATA_W-1:0]  res_hi;
  logic [DATA_W-1:0]  res_lo;
  logic               busy;
  logic               accept;
  logic               commit;

  function automatic logic [2*DATA_W-1:0] mul_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [2*DATA_W-1:0] ae;
    logic [2*DATA_W-1:0] be;
    ae = {{DATA_W{1'b0}}, a};
    be = {{DATA_W{1'b0}}, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}; MIN / -1 wraps to MIN with remainder 0.
  function automatic logic [2*DATA_W-1:0] div_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] min_val;
    min_val = {1'b1, {(DATA_W-1){1'b0}}};
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if ((a == min_val) && (b == '1)) begin
      q = min_val;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] div_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign accept = (state_q == IDLE) && bus.Start && !bus.Op[2];
  assign commit = (state_q == RUN) && (cnt_q == CNT_W'(1));

  // Accept stage: result formed from this cycle's operands.
  always_comb begin
    logic [2*DATA_W-1:0] res;
    res = {hi_q, lo_q};
    case (bus.Op[1:0])
      2'd0: res = mul_signed(bus.A, bus.B);
      2'd1: res = mul_unsigned(bus.A, bus.B);
      2'd2: if (bus.B != '0) res = div_signed(bus.A, bus.B);
      default: if (bus.B != '0) res = div_unsigned(bus.A, bus.B);
    endcase
    res_hi = res[2*DATA_W-1:DATA_W];
    res_lo = res[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= bus.Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Pending stage: held for the full latency, committed on the final edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
      end
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end else if ((state_q == IDLE) && !accept) begin
        if (bus.HI_Write) hi_q <= bus.A;
        if (bus.LO_Write) lo_q <= bus.A;
      end
    end
  end

  assign bus.Busy  = busy;
  assign bus.Stall = bus.isMDFT_D & (bus.Start | busy);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule
